seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a multi-digit common-anode 7-segment display, generalising the single-digit BCD-to-segment decoder to NUM_DIGITS digits.
- Captures a packed BCD word and decodes one digit at a time, segments a..g plus decimal point.
- Rotates the digit-select outputs at a programmable refresh rate, with leading-zero blanking and invalid-code indication.
- Sits between the datapath (counters, ALU results) and the board display pins.

---
 rtl/seg7_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: holds a packed BCD word and
// scans one digit per refresh slot, with leading-zero blanking and dash on invalid codes.
module seg7_scan_driver #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] hold_bcd_p0;
   logic [NUM_DIGITS-1:0]   hold_dp_p0;
   logic [DIV_W-1:0]        div_p0;
   logic [IDX_W-1:0]        idx_p0;
   logic                    tick;
   logic [3:0]              digit_val [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blank;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   // segment order a..g maps to bits 6..0, active-high
   function automatic logic [6:0] decode_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   assign tick = en && (div_p0 == DIV_LAST);

   // stage p0: hold register, refresh divider and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_bcd_p0 <= '0;
         hold_dp_p0  <= '0;
      end else if (load) begin
         hold_bcd_p0 <= bcd_in;
         hold_dp_p0  <= dp_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_p0     <= '0;
         idx_p0     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= tick && (idx_p0 == IDX_LAST);
         if (en)
            div_p0 <= tick ? '0 : div_p0 + 1'b1;
         if (tick)
            idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign digit_val[k] = hold_bcd_p0[4*k +: 4];
   end

   // a digit blanks only while every digit and dp above it (inclusive) is zero
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (hold_bcd_p0[4*k +: 4] == 4'd0) && !hold_dp_p0[k];
         blank[k] = BLANK_LEADING && (k != 0) && zero_run;
      end
   end

   always_comb begin
      an_nxt  = '0;
      seg_nxt = '0;
      dp_nxt  = 1'b0;
      if (en) begin
         an_nxt[idx_p0] = 1'b1;
         if (!blank[idx_p0]) begin
            seg_nxt = decode_seg(digit_val[idx_p0]);
            dp_nxt  = hold_dp_p0[idx_p0];
         end
      end
   end

   // stage p1: registered pin drivers with board polarity applied
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= {NUM_DIGITS{ACTIVE_LOW}};
         seg <= {7{ACTIVE_LOW}};
         dp  <= ACTIVE_LOW;
      end else begin
         an  <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
         seg <= seg_nxt ^ {7{ACTIVE_LOW}};
         dp  <= dp_nxt ^ ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, REFRESH_DIV=4, active-low pins).
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        en = 1'b0;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      bit         chk;
      string      nm;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   localparam logic [6:0] BLANK = 7'b1111111;
   // hand-derived active-low segment codes, a..g on bits 6..0
   logic [6:0] seg_al [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
      7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
   logic [6:0] s1234 [4];

   seg7_scan_driver #(
      .NUM_DIGITS(4),
      .REFRESH_DIV(4),
      .ACTIVE_LOW(1'b1),
      .BLANK_LEADING(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bcd_in(bcd_in),
      .dp_in(dp_in),
      .load(load),
      .en(en),
      .seg(seg),
      .dp(dp),
      .an(an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int d, input logic [6:0] s, input logic dpv,
                               input logic fd, input bit chk, input string nm);
      exp_t e;
      e.an  = (d < 0) ? 4'b1111 : ~(4'b0001 << d);
      e.seg = s;
      e.dp  = dpv;
      e.fd  = fd;
      e.chk = chk;
      e.nm  = nm;
      return e;
   endfunction

   task automatic cyc(input exp_t e);
      @(posedge clk);
      sb_q.push_back(e);
      #1;
   endtask

   // load at slot start (unchecked edge), then check the remaining 15 edges of the frame
   task automatic run_frame(input logic [15:0] b, input logic [3:0] d,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input logic [3:0] edp, input string nm);
      logic [6:0] sv [4];
      sv[0] = e0; sv[1] = e1; sv[2] = e2; sv[3] = e3;
      bcd_in = b;
      dp_in  = d;
      load   = 1'b1;
      cyc(mk(0, 7'd0, 1'b1, 1'b0, 1'b0, nm));
      load = 1'b0;
      for (int j = 1; j < 16; j++)
         cyc(mk(j / 4, sv[j / 4], edp[j / 4], j == 15, 1'b1, nm));
   endtask

   always begin
      @(negedge clk or posedge rst);
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.chk) begin
            n_vec++;
            if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp || frame_done !== mon_e.fd) begin
               n_bad++;
               $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                        mon_e.nm, an, seg, dp, frame_done, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s1234[0] = seg_al[4];
      s1234[1] = seg_al[3];
      s1234[2] = seg_al[2];
      s1234[3] = seg_al[1];

      cyc(mk(-1, BLANK, 1'b1, 1'b0, 1'b1, "reset"));
      cyc(mk(-1, BLANK, 1'b1, 1'b0, 1'b1, "reset"));
      rst    = 1'b0;
      bcd_in = 16'h1234;
      dp_in  = 4'b0000;
      load   = 1'b1;
      cyc(mk(-1, BLANK, 1'b1, 1'b0, 1'b1, "load_dark"));
      load = 1'b0;
      en   = 1'b1;
      for (int j = 0; j < 32; j++)
         cyc(mk((j / 4) % 4, s1234[(j / 4) % 4], 1'b1, (j % 16) == 15, 1'b1, "scan"));

      for (int v = 0; v < 16; v++)
         run_frame({12'h999, 4'(v)}, 4'b0000, seg_al[v], seg_al[9], seg_al[9], seg_al[9],
                   4'b1111, $sformatf("decode_%0d", v));

      run_frame(16'h0070, 4'b0000, seg_al[0], seg_al[7], BLANK, BLANK, 4'b1111, "blank_0070");
      run_frame(16'h0070, 4'b0100, seg_al[0], seg_al[7], seg_al[0], BLANK, 4'b1011, "blank_dp2");
      run_frame(16'h0A00, 4'b0000, seg_al[0], seg_al[0], seg_al[10], BLANK, 4'b1111, "blank_inval");
      run_frame(16'h0000, 4'b0000, seg_al[0], BLANK, BLANK, BLANK, 4'b1111, "blank_all0");
      run_frame(16'h1234, 4'b0001, seg_al[4], seg_al[3], seg_al[2], seg_al[1], 4'b1110, "dp0");
      run_frame(16'h1234, 4'b0000, seg_al[4], seg_al[3], seg_al[2], seg_al[1], 4'b1111, "reload");

      // freeze two cycles into digit 2's slot, then let it finish
      for (int j = 0; j < 10; j++)
         cyc(mk(j / 4, s1234[j / 4], 1'b1, 1'b0, 1'b1, "freeze_pre"));
      en = 1'b0;
      repeat (10) cyc(mk(-1, BLANK, 1'b1, 1'b0, 1'b1, "freeze_off"));
      en = 1'b1;
      for (int j = 10; j < 16; j++)
         cyc(mk(j / 4, s1234[j / 4], 1'b1, j == 15, 1'b1, "freeze_resume"));

      for (int j = 0; j < 3; j++)
         cyc(mk(0, s1234[0], 1'b1, 1'b0, 1'b1, "coll_pre"));
      bcd_in = 16'h5678;
      load   = 1'b1;
      cyc(mk(0, s1234[0], 1'b1, 1'b0, 1'b1, "coll_tick"));
      load = 1'b0;
      for (int j = 4; j < 8; j++)
         cyc(mk(1, seg_al[7], 1'b1, 1'b0, 1'b1, "coll_new"));

      @(negedge clk);
      #2;
      sb_q.push_back(mk(-1, BLANK, 1'b1, 1'b0, 1'b1, "async_rst"));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int j = 0; j < 4; j++)
         cyc(mk(0, seg_al[0], 1'b1, 1'b0, 1'b1, "post_rst"));
      cyc(mk(1, BLANK, 1'b1, 1'b0, 1'b1, "post_rst_blank"));

      repeat (2) @(negedge clk);
      #3;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
